// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared FSM state encodings and hold counter width for rr_arb_fsm
package rr_arb_pkg;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;
  localparam int CNT_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, used by rr_arb_fsm only when RR_ARB_REQ_SYNC_EN is defined
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  // shift d through two flops, both cleared by reset
  always_ff @(posedge clk)
    if (reset) {m, q} <= 2'b00;
    else {m, q} <= {d, m};
endmodule

// File: rtl/rr_arb_fsm.sv
// rr_arb_fsm: round-robin Moore arbiter with hold limit; RR_ARB_REQ_SYNC_EN adds 2-ff request synchronizers
module rr_arb_fsm
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_id,
  output logic             busy,
  output logic             timeout
);
  logic [N_REQ-1:0] req_s;
  logic [7:0]       req_p;
  logic [1:0]       state, state_n;
  logic [2:0]       owner, owner_n, last_winner, lw_n, pick;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic             to_n;
`ifdef RR_ARB_REQ_SYNC_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_sync
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(req[i]), .q(req_s[i]));
  end
`else
  assign req_s = req;
`endif
  assign req_p  = 8'(req_s);
  assign busy   = state == GRANT;
  assign gnt    = busy ? N_REQ'(1) << owner : '0;
  assign gnt_id = busy ? owner : 3'd0;
  // state and datapath registers
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      owner       <= 3'd0;
      last_winner <= 3'(N_REQ - 1);
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last_winner <= lw_n;
      hold_cnt    <= cnt_n;
      timeout     <= to_n;
    end
  // round-robin pick and next-state logic; descending loop leaves the nearest set bit after last_winner
  always_comb begin
    state_n = IDLE;
    owner_n = owner;
    lw_n    = last_winner;
    cnt_n   = hold_cnt;
    to_n    = 1'b0;
    pick    = 3'd0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_p[3'((int'(last_winner) + k) % N_REQ)]) pick = 3'((int'(last_winner) + k) % N_REQ);
    case (state)
      IDLE: if (|req_s) begin
        state_n = GRANT;
        owner_n = pick;
        lw_n    = pick;
        cnt_n   = '0;
      end
      GRANT: begin
        cnt_n   = hold_cnt + 1'b1;
        state_n = !req_p[owner] || hold_cnt == CNT_W'(MAX_HOLD - 1) ? GAP : GRANT;
        to_n    = req_p[owner] && hold_cnt == CNT_W'(MAX_HOLD - 1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rr_arb_fsm.sv
// tb_rr_arb_fsm: directed self-checking bench for rr_arb_fsm (N_REQ=4, MAX_HOLD=16)
module tb_rr_arb_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] gnt_id;
  logic       busy, timeout;
  int tests = 0;
  int fails = 0;
`ifdef RR_ARB_REQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  rr_arb_fsm #(.N_REQ(4), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drain();
    req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    reset = 1'b1;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_id", 32'(gnt_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(timeout), 0);
    reset = 1'b0;
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
        chk("rr_id", 32'(gnt_id), 32'(g % 4));
        chk("rr_busy", 32'(busy), 1);
        if (c == 2) req[g % 4] = 1'b0;
      end
      @(negedge clk);
      chk("rr_gap", 32'(gnt), 0);
      chk("rr_gap_to", 32'(timeout), 0);
      req = 4'b1111;
      @(negedge clk);
      chk("rr_idle", 32'(gnt), 0);
    end
    @(negedge clk);
    drain();
    req = 4'b0100;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("hold_gnt", 32'(gnt), 32'h4);
      chk("hold_to", 32'(timeout), 0);
    end
    @(negedge clk);
    chk("to_gap_gnt", 32'(gnt), 0);
    chk("to_pulse", 32'(timeout), 1);
    @(negedge clk);
    chk("to_idle_gnt", 32'(gnt), 0);
    chk("to_clear", 32'(timeout), 0);
    @(negedge clk);
    chk("regrant", 32'(gnt), 32'h4);
    drain();
    req = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("edge_gnt", 32'(gnt), 32'h2);
      if (c == 16) req = 4'b0000;
    end
    @(negedge clk);
    chk("edge_gnt0", 32'(gnt), 0);
    chk("edge_to", 32'(timeout), 0);
    chk("edge_busy", 32'(busy), 0);
    drain();
    req = 4'b1000;
    repeat (2) @(negedge clk);
    chk("g3_gnt", 32'(gnt), 32'h8);
    chk("g3_id", 32'(gnt_id), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_to", 32'(timeout), 0);
    chk("mid_rst_id", 32'(gnt_id), 0);
    reset = 1'b0;
    req   = 4'b1001;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_id", 32'(gnt_id), 0);
    drain();
    force dut.state = 2'b11;
    #1;
    release dut.state;
    chk("ill_gnt", 32'(gnt), 0);
    chk("ill_busy", 32'(busy), 0);
    @(negedge clk);
    chk("ill_state", 32'(dut.state), 0);
    chk("ill_gnt_next", 32'(gnt), 0);
    req = 4'b0010;
    n = 0;
    while (n < 10 && gnt !== 4'b0010) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("lat_gnt", 32'(gnt), 32'h2);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arb_fsm.md
RR_ARB_FSM -- requirements
Module: rr_arb_fsm

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 16, maximum grant length in cycles (2..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled only on posedge clk.
REQ-005 req  input  N_REQ  per-requester request level; held high while the requester wants or holds the resource.
REQ-006 gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner.
REQ-007 gnt_id  output  3  index of current owner; valid only while busy=1, 0 otherwise.
REQ-008 busy  output  1  high while in GRANT.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL be a Moore FSM with states IDLE, GRANT and GAP; gnt, gnt_id and busy SHALL be functions of registered state only.
REQ-011 IDLE: if any req bit is high, select the first set bit searching upward from last_winner+1 modulo N_REQ, load owner and last_winner, clear hold counter, and go to GRANT; otherwise stay in IDLE.
REQ-012 Latency: req seen high at edge k SHALL produce gnt high after edge k (visible in cycle k+1) when the FSM is in IDLE.
REQ-013 GRANT: hold counter increments by 1 each cycle; if req[owner]=0, go to GAP; else if counter = MAX_HOLD-1, pulse timeout and go to GAP; else stay.
REQ-014 Release and hold-limit expiry in the same cycle SHALL count as release: timeout stays 0.
REQ-015 GAP: gnt all-zero for exactly one cycle, then go to IDLE unconditionally.
REQ-016 Requests from non-owners during GRANT or GAP SHALL be ignored until IDLE arbitration; no request is latched.
REQ-017 A timed-out requester SHALL receive no priority change beyond normal round-robin order.
REQ-018 Hold counter SHALL be 8 bits and SHALL never wrap (bounded by REQ-013).
REQ-019 Illegal state encodings SHALL return to IDLE on the next edge with gnt all-zero.

Reset
REQ-020 On reset: state IDLE, gnt 0, gnt_id 0, busy 0, timeout 0, hold counter 0, last_winner N_REQ-1 (requester 0 has first priority).
REQ-021 Reset asserted during GRANT SHALL clear gnt at the same edge, with no timeout pulse.

Configuration
REQ-022 Macro RR_ARB_REQ_SYNC_EN: when defined, each req bit SHALL pass through a 2-flip-flop synchronizer before the FSM, adding 2 cycles to REQ-012 latency and release detection; synchronizer flops reset to 0.
REQ-023 Without RR_ARB_REQ_SYNC_EN, req SHALL feed the FSM directly and callers SHALL supply req synchronous to clk.

Structure
REQ-024 State encodings (IDLE=2'b00, GRANT=2'b01, GAP=2'b10) and the hold counter width constant SHALL live in shared package rr_arb_pkg.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, instantiated N_REQ times) used only under RR_ARB_REQ_SYNC_EN.
REQ-026 The state register and next-state/output logic SHALL be two separate processes (sequential, combinational with default assignments).

Verification (N_REQ=4, MAX_HOLD=16, macro undefined unless stated)
REQ-027 After reset, req=4'b1111 held with each owner dropping after 3 cycles -> grants in order 0,1,2,3,0, each 3 cycles, one GAP cycle between.
REQ-028 req=4'b0100 held high -> gnt=4'b0100 for 16 cycles, timeout pulse 1 cycle, GAP, then re-grant to 2.
REQ-029 Owner 1 drops req on the same cycle the counter reaches 15 -> GAP entered, timeout=0.
REQ-030 reset asserted during a grant to requester 3 -> gnt=0, busy=0 next edge; following req=4'b1001 grants requester 0 first.
REQ-031 req=4'b0010 with RR_ARB_REQ_SYNC_EN defined -> gnt=4'b0010 appears 3 cycles after req rises (vs 1 cycle without).
REQ-032 Forced illegal state 2'b11 -> IDLE and gnt=0 on the next edge.
